// File: rtl/count_seg_display_pkg.sv
// Shared types and constants for the two-digit count display.
// Digit-slot state encoding, active-low segment patterns and the default refresh divider.
package count_seg_display_pkg;

    typedef enum logic {
        DIG_ONES = 1'b0,
        DIG_TENS = 1'b1
    } dig_state_e;

    // Active-low patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam int REFRESH_DIV_DEFAULT = 50000;

endpackage

// File: rtl/count_seg_display_seg7_decode.sv
// Combinational BCD digit to active-low 7-segment decoder.
// Codes above 9 light nothing.
module seg7_decode
    import count_seg_display_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Digit lookup
    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/count_seg_display.sv
// Shows a 0..15 count as two multiplexed decimal digits and pulses chg when the count moves.
// Optional macro LEADING_ZERO_BLANK_EN darkens the tens digit when it would show "0".
module count_seg_display
    import count_seg_display_pkg::*;
#(
    parameter int REFRESH_DIV = REFRESH_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rs,
    input  logic [3:0] q_in,
    output logic [1:0] an,
    output logic [6:0] seg,
    output logic       chg
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] REF_LAST = CW'(REFRESH_DIV - 1);

    logic [3:0]    q_s_q, q_s_d;
    logic [3:0]    q_d_q, q_d_d;
    logic [3:0]    snap_q, snap_d;
    logic [CW-1:0] ref_cnt_q, ref_cnt_d;
    dig_state_e    state_q, state_d;
    logic [1:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          chg_q, chg_d;

    logic          tens_s;
    logic [3:0]    ones_s;
    logic [3:0]    digit_s;
    logic [6:0]    dec_seg_s;

    seg7_decode u_dec (
        .digit (digit_s),
        .seg   (dec_seg_s)
    );

    // Split the snapshot into decimal digits and pick the one for the current slot
    always_comb begin
        tens_s  = (snap_q >= 4'd10);
        ones_s  = tens_s ? (snap_q - 4'd10) : snap_q;
        digit_s = ones_s;
        if (state_q == DIG_TENS) begin
            digit_s = {3'b000, tens_s};
        end else begin
            digit_s = ones_s;
        end
    end

    // Next-state: input pipeline, refresh timing, frame snapshot and output drive
    always_comb begin
        q_s_d     = q_in;
        q_d_d     = q_s_q;
        chg_d     = (q_s_q != q_d_q);
        ref_cnt_d = ref_cnt_q + CW'(1);
        state_d   = state_q;
        snap_d    = snap_q;
        an_d      = 2'b11;
        seg_d     = SEG_BLANK;

        if (ref_cnt_q == REF_LAST) begin
            ref_cnt_d = '0;
            state_d   = (state_q == DIG_ONES) ? DIG_TENS : DIG_ONES;
            // Snapshot only at frame start so both digits come from one value
            if (state_q == DIG_TENS) begin
                snap_d = q_s_q;
            end else begin
                snap_d = snap_q;
            end
        end else begin
            ref_cnt_d = ref_cnt_q + CW'(1);
            state_d   = state_q;
        end

        case (state_q)
            DIG_ONES: begin
                an_d  = 2'b10;
                seg_d = dec_seg_s;
            end
            DIG_TENS: begin
`ifdef LEADING_ZERO_BLANK_EN
                if (!tens_s) begin
                    an_d  = 2'b11;
                    seg_d = SEG_BLANK;
                end else begin
                    an_d  = 2'b01;
                    seg_d = dec_seg_s;
                end
`else
                an_d  = 2'b01;
                seg_d = dec_seg_s;
`endif
            end
            default: begin
                an_d  = 2'b11;
                seg_d = SEG_BLANK;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rs) begin
            q_s_q     <= 4'd0;
            q_d_q     <= 4'd0;
            snap_q    <= 4'd0;
            ref_cnt_q <= '0;
            state_q   <= DIG_ONES;
            an_q      <= 2'b11;
            seg_q     <= SEG_BLANK;
            chg_q     <= 1'b0;
        end else begin
            q_s_q     <= q_s_d;
            q_d_q     <= q_d_d;
            snap_q    <= snap_d;
            ref_cnt_q <= ref_cnt_d;
            state_q   <= state_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            chg_q     <= chg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign chg = chg_q;

endmodule

// File: tb/tb_count_seg_display.sv
// Scoreboard bench for count_seg_display: per-edge expectations come from an input-history model.
module tb_count_seg_display;

    localparam int D = 4;

    typedef struct {
        logic [1:0] an;
        logic [6:0] seg;
        logic       chg;
        int         edge_no;
    } exp_t;

    logic       clk = 1'b0;
    logic       rs = 1'b0;
    logic [3:0] q_in = 4'd0;
    logic [1:0] an;
    logic [6:0] seg;
    logic       chg;

    exp_t exp_q[$];
    int   hist[$];
    int   total = 0;
    int   bad = 0;
    int   edge_cnt = 0;
    logic [6:0] seg_tbl [10];

    count_seg_display #(.REFRESH_DIV(D)) dut (
        .clk  (clk),
        .rs   (rs),
        .q_in (q_in),
        .an   (an),
        .seg  (seg),
        .chg  (chg)
    );

    always #5 clk = ~clk;

    // Drive one edge's inputs and push what the outputs must be after that edge
    task automatic step(input logic r, input logic [3:0] v);
        exp_t e;
        int kk, slot, frame, val, p1, p2;
        @(negedge clk);
        rs   = r;
        q_in = v;
        e.edge_no = edge_cnt;
        edge_cnt++;
        if (!r) begin
            hist.delete();
            e.an = 2'b11; e.seg = 7'h7F; e.chg = 1'b0;
        end else begin
            kk = hist.size();
            hist.push_back(int'(v));
            slot  = (kk / D) % 2;
            frame = kk / (2 * D);
            // Frame f shows the value sampled two edges before it begins
            val = (frame == 0) ? 0 : hist[2 * D * frame - 2];
            p1  = (kk >= 1) ? hist[kk - 1] : 0;
            p2  = (kk >= 2) ? hist[kk - 2] : 0;
            e.chg = (p1 != p2);
            if (slot == 0) begin
                e.an = 2'b10; e.seg = seg_tbl[val % 10];
            end else begin
`ifdef LEADING_ZERO_BLANK_EN
                if (val / 10 == 0) begin
                    e.an = 2'b11; e.seg = 7'h7F;
                end else begin
                    e.an = 2'b01; e.seg = seg_tbl[val / 10];
                end
`else
                e.an = 2'b01; e.seg = seg_tbl[val / 10];
`endif
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic hold(input logic [3:0] v, input int n);
        for (int i = 0; i < n; i++) step(1'b1, v);
    endtask

    // Monitor: every edge that had stimulus is compared just after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (an !== e.an || seg !== e.seg || chg !== e.chg) begin
                    bad++;
                    $display("FAIL outputs edge=%0d an=%b exp=%b seg=%h exp=%h chg=%b exp=%b",
                             e.edge_no, an, e.an, seg, e.seg, chg, e.chg);
                end
            end
        end
    end

    initial begin
        seg_tbl[0] = 7'h40; seg_tbl[1] = 7'h79; seg_tbl[2] = 7'h24; seg_tbl[3] = 7'h30;
        seg_tbl[4] = 7'h19; seg_tbl[5] = 7'h12; seg_tbl[6] = 7'h02; seg_tbl[7] = 7'h78;
        seg_tbl[8] = 7'h00; seg_tbl[9] = 7'h10;

        step(1'b0, 4'd0);
        step(1'b0, 4'd0);
        hold(4'd0, 12);
        hold(4'd7, 24);
        hold(4'd13, 24);
        hold(4'd15, 20);
        hold(4'd0, 24);

        // Change lands on the tens-slot terminal edge
        while (hist.size() % (2 * D) != 2 * D - 1) step(1'b1, 4'd9);
        hold(4'd2, 24);

        // Reset in the middle of a slot
        while (hist.size() % (2 * D) != 2) step(1'b1, 4'd11);
        step(1'b0, 4'd5);
        hold(4'd5, 20);

        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                step(1'b0, 4'($urandom_range(0, 15)));
            end else if ($urandom_range(0, 4) == 0) begin
                step(1'b1, 4'($urandom_range(0, 15)));
            end else begin
                step(1'b1, q_in);
            end
        end

        @(posedge clk);
        #3;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/count_seg_display.md
Name: count_seg_display

Overview:
- Downstream consumer of the 4-bit counter output `q`.
- Takes the 0..15 count and drives a 2-digit multiplexed common-anode 7-segment display in decimal (00..15).
- Pulses a change flag whenever the count moves.
- Sits between the counter top and the board display pins.

Parameters:
- REFRESH_DIV, 50000, clock cycles each digit stays lit (minimum 2; the bench uses 4).

Ports:
- clk  input  1  system clock, rising-edge.
- rs  input  1  reset; synchronous, active-low.
- q_in  input  4  count value from the upstream counter.
- an  output  2  digit anode enables, active-low; an[0]=ones, an[1]=tens.
- seg  output  7  segments, active-low, bit order {g,f,e,d,c,b,a}.
- chg  output  1  one-cycle pulse on a count change.

Behaviour:
- All outputs are registered. Reset values: an=2'b11, seg=7'h7F, chg=0. Internal reset values: q_s=0, q_d=0, snap=0, ref_cnt=0, state=DIG_ONES.
- Input stage:
  - q_s <= q_in; q_d <= q_s each cycle.
  - chg <= (q_s != q_d).
  - A new q_in value sampled at edge N gives chg=1 for exactly the cycle after edge N+1.
  - A value held steady gives no further pulses. Back-to-back changes give one pulse per change.
- Refresh counter:
  - ref_cnt counts 0..REFRESH_DIV-1 and wraps to 0.
  - At the terminal count, state toggles DIG_ONES <-> DIG_TENS.
- Snapshot:
  - snap <= q_s only on the DIG_TENS->DIG_ONES transition.
  - Both digits of one display frame therefore come from the same value (no tearing).
  - Latency from q_in change to display is at most 2*REFRESH_DIV+3 cycles.
- Digit split:
  - tens = (snap >= 10); ones = tens ? snap-10 : snap. Use 4-bit arithmetic with no overflow path.
- Output registers:
  - State DIG_ONES: an <= 2'b10, seg <= enc(ones).
  - State DIG_TENS: an <= 2'b01, seg <= enc(tens).
  - Each digit is lit for exactly REFRESH_DIV consecutive cycles.
  - The first edge with rs=1 after reset gives an=2'b10, seg=7'h40 ("0").
- Encoding, hex digits 0-9: 40,79,24,30,19,12,02,78,00,10. Anything else gives 7F (blank); this is unreachable by construction.
- Boundary q_in=15: displays "15". q_in 15->0 (counter wrap): chg pulses and the display shows "00" from the next frame.
- Reset mid-operation: rs=0 at any edge forces all reset values at that edge, regardless of state or ref_cnt. No partial frame survives.
- Simultaneous events: a q_in change on the same edge as the frame boundary is not snapshotted (snap takes the old q_s) and appears in the following frame.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: in DIG_TENS with tens=0, an <= 2'b11 and seg <= 7'h7F (tens digit dark). Slot timing is unchanged.
- Undefined: the tens digit always shows "0" or "1".

Decomposition:
- Shared package/include holds:
  - state encoding DIG_ONES=1'b0, DIG_TENS=1'b1;
  - segment constants SEG_0..SEG_9 and SEG_BLANK=7'h7F;
  - the default REFRESH_DIV.
- One sub-module: seg7_decode (4-bit digit in, 7-bit active-low segments out, combinational). The parent registers its output.
- The refresh counter, FSM, sync/change-detect and snapshot stay in count_seg_display.

Test Plan (REFRESH_DIV=4):
- Reset: rs=0 for 2 edges, then release with q_in=0 -> during reset an=11, seg=7F, chg=0. First post-reset cycle an=10, seg=40. The tens slot starts 4 cycles later with an=01, seg=40.
- Change detect: q_in 0->7 held -> chg=1 for exactly one cycle, two edges after sampling. The next frame shows ones seg=78 and tens seg=40.
- Two-digit value: q_in=13 -> ones slot seg=30 and tens slot seg=79, each for exactly 4 cycles, alternating.
- Wrap: q_in 15->0 -> chg pulse, frame "15" (12/79) followed by "00" (40/40). No frame mixes digits of 15 and 0.
- Boundary race plus mid-frame reset:
  - q_in changes on the DIG_TENS terminal edge -> the old value is shown for one more full frame.
  - rs=0 asserted mid-slot -> an=11, seg=7F and ref_cnt=0 at that edge.
- Option: compile with LEADING_ZERO_BLANK_EN and q_in=5 -> tens slot an=11, seg=7F for 4 cycles. Without the macro -> tens slot an=01, seg=40.
